// File: rtl/manchester_pkg.sv
// manchester_pkg: shared types, constants and the line encoder for the
// framed Manchester transmitter.
package manchester_pkg;

   typedef enum logic [1:0] {
      IDLE,
      PREAMBLE,
      DATA,
      TAIL
   } tx_state_t;

   // Level on the line whenever the driver is disabled.
   localparam logic LINE_IDLE_LEVEL = 1'b0;

   // Bit times of quiet line (driver still enabled) after the last byte.
   localparam int TAIL_BITS = 2;

   // ph=0 is the first half-bit, ph=1 the second; inv selects G.E. Thomas.
   function automatic logic manch_enc(input logic b, input logic ph, input logic inv);
      return (b ^ ~ph) ^ inv;
   endfunction

endpackage

// File: rtl/manchester_bit_timer.sv
// manchester_bit_timer: half-bit divider and phase flop. half_tick marks the
// terminal count of the divider, bit_end marks the last cycle of a bit.
module manchester_bit_timer #(
   parameter int HALF_BIT_CYCLES = 4
) (
   input  logic clk_sys,
   input  logic rst_n,
   input  logic i_run,
   input  logic i_clear,
   output logic o_half_tick,
   output logic o_ph,
   output logic o_bit_end
);

   localparam int DIV_W = $clog2(HALF_BIT_CYCLES);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF_BIT_CYCLES - 1);

   logic [DIV_W-1:0] r_div;
   logic             r_ph;

   assign o_half_tick = i_run && (r_div == DIV_LAST);
   assign o_ph        = r_ph;
   assign o_bit_end   = o_half_tick && r_ph;

   // Divider wraps on the terminal count; phase flips every half-bit.
   always_ff @(posedge clk_sys) begin
      if (!rst_n || i_clear) begin
         r_div <= '0;
         r_ph  <= 1'b0;
      end else if (o_half_tick) begin
         r_div <= '0;
         r_ph  <= ~r_ph;
      end else if (i_run) begin
         r_div <= r_div + DIV_W'(1);
      end
   end

endmodule

// File: rtl/manchester_frame_tx.sv
// manchester_frame_tx: framed Manchester transmitter with valid/ready input.
// Frame = preamble/SFD, one or more bytes MSB-first, then a quiet tail.
// Optional macro MANCH_TX_PARITY_EN appends an even-parity bit to each byte.
module manchester_frame_tx
   import manchester_pkg::*;
#(
   parameter int   HALF_BIT_CYCLES = 4,
   parameter int   PREAMBLE_BITS   = 8,
   parameter logic INVERT_POLARITY = 1'b0
) (
   input  logic       clk_sys,
   input  logic       rst_n,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       manchester_out,
   output logic       tx_oe,
   output logic       tx_busy
);

   localparam int IDX_W = $clog2((PREAMBLE_BITS > 9) ? PREAMBLE_BITS : 9);
`ifdef MANCH_TX_PARITY_EN
   localparam int BITS_PER_BYTE = 9;
`else
   localparam int BITS_PER_BYTE = 8;
`endif
   localparam logic [IDX_W-1:0] PRE_LAST  = IDX_W'(PREAMBLE_BITS - 1);
   localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(BITS_PER_BYTE - 1);
   localparam logic [IDX_W-1:0] TAIL_LAST = IDX_W'(TAIL_BITS - 1);
   // The tail is a driven logical 0, so it follows the polarity setting.
   localparam logic TAIL_LEVEL = LINE_IDLE_LEVEL ^ INVERT_POLARITY;

   tx_state_t        r_state;
   logic [IDX_W-1:0] r_idx;
   logic [7:0]       r_shift;
   logic             r_out;
   logic             r_oe;
   logic             r_busy;
`ifdef MANCH_TX_PARITY_EN
   logic             r_par;
`endif

   logic             w_half_tick;
   logic             w_ph;
   logic             w_bit_end;
   logic             w_ready_slot;
   logic             w_xfer;
   logic             w_cur_bit;
   logic             w_next_bit;
   logic [IDX_W-1:0] w_idx_inc;

   // Preamble alternates 1,0,... and ends with an extra 1 forming the SFD.
   function automatic logic pre_bit(input logic [IDX_W-1:0] i);
      return (i == PRE_LAST) ? 1'b1 : ~i[0];
   endfunction

   manchester_bit_timer #(
      .HALF_BIT_CYCLES(HALF_BIT_CYCLES)
   ) u_timer (
      .clk_sys    (clk_sys),
      .rst_n      (rst_n),
      .i_run      (r_state != IDLE),
      .i_clear    ((r_state == IDLE) && w_xfer),
      .o_half_tick(w_half_tick),
      .o_ph       (w_ph),
      .o_bit_end  (w_bit_end)
   );

   assign w_ready_slot = (r_state == DATA) && w_bit_end && (r_idx == DATA_LAST);
   assign tx_ready     = rst_n && ((r_state == IDLE) || w_ready_slot);
   assign w_xfer       = tx_valid && tx_ready;
   assign w_idx_inc    = r_idx + IDX_W'(1);

`ifdef MANCH_TX_PARITY_EN
   assign w_cur_bit  = (r_idx == DATA_LAST) ? r_par : r_shift[7];
   assign w_next_bit = (r_idx == DATA_LAST - IDX_W'(1)) ? r_par : r_shift[6];
`else
   assign w_cur_bit  = r_shift[7];
   assign w_next_bit = r_shift[6];
`endif

   assign manchester_out = r_out;
   assign tx_oe          = r_oe;
   assign tx_busy        = r_busy;

   // Frame sequencer; r_out is loaded with the level of the following cycle.
   always_ff @(posedge clk_sys) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_idx   <= '0;
         r_shift <= '0;
         r_out   <= LINE_IDLE_LEVEL;
         r_oe    <= 1'b0;
         r_busy  <= 1'b0;
`ifdef MANCH_TX_PARITY_EN
         r_par   <= 1'b0;
`endif
      end else begin
         case (r_state)
            IDLE: begin
               if (w_xfer) begin
                  r_shift <= tx_data;
`ifdef MANCH_TX_PARITY_EN
                  r_par   <= ^tx_data;
`endif
                  r_idx   <= '0;
                  r_state <= PREAMBLE;
                  r_oe    <= 1'b1;
                  r_busy  <= 1'b1;
                  r_out   <= manch_enc(pre_bit(IDX_W'(0)), 1'b0, INVERT_POLARITY);
               end
            end
            PREAMBLE: begin
               if (w_bit_end) begin
                  if (r_idx == PRE_LAST) begin
                     r_state <= DATA;
                     r_idx   <= '0;
                     r_out   <= manch_enc(r_shift[7], 1'b0, INVERT_POLARITY);
                  end else begin
                     r_idx <= w_idx_inc;
                     r_out <= manch_enc(pre_bit(w_idx_inc), 1'b0, INVERT_POLARITY);
                  end
               end else if (w_half_tick) begin
                  r_out <= manch_enc(pre_bit(r_idx), ~w_ph, INVERT_POLARITY);
               end
            end
            DATA: begin
               if (w_bit_end) begin
                  if (r_idx == DATA_LAST) begin
                     if (w_xfer) begin
                        r_shift <= tx_data;
`ifdef MANCH_TX_PARITY_EN
                        r_par   <= ^tx_data;
`endif
                        r_idx   <= '0;
                        r_out   <= manch_enc(tx_data[7], 1'b0, INVERT_POLARITY);
                     end else begin
                        r_state <= TAIL;
                        r_idx   <= '0;
                        r_out   <= TAIL_LEVEL;
                     end
                  end else begin
                     r_idx   <= w_idx_inc;
                     r_shift <= {r_shift[6:0], 1'b0};
                     r_out   <= manch_enc(w_next_bit, 1'b0, INVERT_POLARITY);
                  end
               end else if (w_half_tick) begin
                  r_out <= manch_enc(w_cur_bit, ~w_ph, INVERT_POLARITY);
               end
            end
            TAIL: begin
               if (w_bit_end) begin
                  if (r_idx == TAIL_LAST) begin
                     r_state <= IDLE;
                     r_idx   <= '0;
                     r_oe    <= 1'b0;
                     r_busy  <= 1'b0;
                     r_out   <= LINE_IDLE_LEVEL;
                  end else begin
                     r_idx <= w_idx_inc;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_manchester_frame_tx.sv
// Directed bench for manchester_frame_tx (default parameters) with a second
// instance using INVERT_POLARITY=1. Honours MANCH_TX_PARITY_EN when defined.
module tb_manchester_frame_tx;

`ifdef MANCH_TX_PARITY_EN
   localparam int BPB = 9;
`else
   localparam int BPB = 8;
`endif
   localparam int BYTE_CYC = 8 * BPB;

   logic       clk_sys = 1'b0;
   logic       rst_n;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready,     manchester_out,     tx_oe,     tx_busy;
   logic       tx_ready_inv, manchester_out_inv, tx_oe_inv, tx_busy_inv;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk_sys = ~clk_sys;

   manchester_frame_tx dut (
      .clk_sys       (clk_sys),
      .rst_n         (rst_n),
      .tx_data       (tx_data),
      .tx_valid      (tx_valid),
      .tx_ready      (tx_ready),
      .manchester_out(manchester_out),
      .tx_oe         (tx_oe),
      .tx_busy       (tx_busy)
   );

   manchester_frame_tx #(.INVERT_POLARITY(1'b1)) dut_inv (
      .clk_sys       (clk_sys),
      .rst_n         (rst_n),
      .tx_data       (tx_data),
      .tx_valid      (tx_valid),
      .tx_ready      (tx_ready_inv),
      .manchester_out(manchester_out_inv),
      .tx_oe         (tx_oe_inv),
      .tx_busy       (tx_busy_inv)
   );

   task automatic chk(input string name, input string tag, input int c,
                      input logic obs, input logic exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s.%s cycle=%0d observed=%b expected=%b", name, tag, c, obs, exp);
      end
   endtask

   // Bit number idx of the line stream: preamble/SFD, then bytes (plus parity).
   function automatic logic exp_bit(input int idx, input logic [7:0] d0, input logic [7:0] d1);
      logic [7:0] pre;
      logic [7:0] byt;
      int k, pos;
      pre = 8'b1010_1011;
      if (idx < 8) return pre[7-idx];
      k   = (idx - 8) / BPB;
      pos = (idx - 8) % BPB;
      byt = (k == 0) ? d0 : d1;
      if (pos == 8) return ^byt;
      return byt[7-pos];
   endfunction

   // Called at a negedge with the DUT idle: offers d0 (accept cycle 0), then
   // checks every cycle up to the first idle cycle. tx_valid stays high with
   // d1 on the bus for edges ending cycles < v_to. At cycle stop_c rst_n is
   // pulled low and the task returns.
   task automatic frame(input string name, input logic [7:0] d0, input logic [7:0] d1,
                        input int nb, input int v_to, input int stop_c, input bit chk_inv);
      int   last_data;
      logic ph, e_out, e_oe, e_busy, e_rdy;
      last_data = 64 + BYTE_CYC * nb;
      tx_data  = d0;
      tx_valid = 1'b1;
      #1;
      chk(name, "rdy_accept", 0, tx_ready, 1'b1);
      for (int c = 1; c <= last_data + 17; c++) begin
         @(negedge clk_sys);
         if (c <= last_data) begin
            ph     = (((c - 1) % 8) >= 4);
            e_out  = exp_bit((c - 1) / 8, d0, d1) ^ ~ph;
            e_oe   = 1'b1;
            e_busy = 1'b1;
            e_rdy  = (c > 64) && (((c - 64) % BYTE_CYC) == 0);
         end else if (c <= last_data + 16) begin
            e_out  = 1'b0;
            e_oe   = 1'b1;
            e_busy = 1'b1;
            e_rdy  = 1'b0;
         end else begin
            e_out  = 1'b0;
            e_oe   = 1'b0;
            e_busy = 1'b0;
            e_rdy  = 1'b1;
         end
         chk(name, "out",  c, manchester_out, e_out);
         chk(name, "oe",   c, tx_oe,          e_oe);
         chk(name, "busy", c, tx_busy,        e_busy);
         chk(name, "rdy",  c, tx_ready,       e_rdy);
         if (chk_inv) begin
            chk(name, "inv_out",  c, manchester_out_inv, (c <= last_data + 16) ? ~e_out : 1'b0);
            chk(name, "inv_oe",   c, tx_oe_inv,   e_oe);
            chk(name, "inv_busy", c, tx_busy_inv, e_busy);
            chk(name, "inv_rdy",  c, tx_ready_inv, e_rdy);
         end
         if (c == stop_c) begin
            rst_n = 1'b0;
            return;
         end
         tx_valid = (c < v_to) ? 1'b1 : 1'b0;
         tx_data  = d1;
      end
   endtask

   initial begin
      rst_n    = 1'b0;
      tx_valid = 1'b0;
      tx_data  = 8'h00;
      repeat (3) @(negedge clk_sys);
      chk("reset", "out",      0, manchester_out,     1'b0);
      chk("reset", "oe",       0, tx_oe,              1'b0);
      chk("reset", "busy",     0, tx_busy,            1'b0);
      chk("reset", "rdy",      0, tx_ready,           1'b0);
      chk("reset", "inv_out",  0, manchester_out_inv, 1'b0);
      chk("reset", "inv_oe",   0, tx_oe_inv,          1'b0);
      rst_n = 1'b1;
      #1;
      chk("reset", "rdy_release", 0, tx_ready, 1'b1);

      // Single byte, tx_valid low during DATA; inverted instance checked too.
      frame("single_a5", 8'hA5, 8'h00, 1, 1, 0, 1'b1);

      // Back-to-back bytes with tx_valid held through the load cycle.
      frame("b2b_00_ff", 8'h00, 8'hFF, 2, 64 + BYTE_CYC + 1, 0, 1'b0);

      // tx_valid held high in DATA but dropped on the load cycle: one byte only.
      frame("valid_ignored", 8'h3C, 8'hFF, 1, 64 + BYTE_CYC, 0, 1'b0);

      // Parity-relevant pattern (odd weight) and an all-ones-ish edge pattern.
      frame("byte_07", 8'h07, 8'h00, 1, 1, 0, 1'b0);

      // Reset mid-frame at cycle 70, then a fresh frame.
      frame("rst_mid", 8'h5A, 8'h00, 1, 1, 70, 1'b0);
      #1;
      chk("rst_mid", "rdy_in_reset", 70, tx_ready, 1'b0);
      @(negedge clk_sys);
      chk("rst_mid", "out",  71, manchester_out, 1'b0);
      chk("rst_mid", "oe",   71, tx_oe,          1'b0);
      chk("rst_mid", "busy", 71, tx_busy,        1'b0);
      chk("rst_mid", "rdy",  71, tx_ready,       1'b0);
      rst_n = 1'b1;
      #1;
      chk("rst_mid", "rdy_release", 71, tx_ready, 1'b1);
      frame("after_rst", 8'h81, 8'h00, 1, 1, 0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/manchester_frame_tx.md
Name: manchester_frame_tx

Overview:
Single-clock Manchester frame transmitter. It accepts bytes over a valid/ready handshake and emits a framed Manchester line signal that the existing manchester_decoder receives. Each frame is a preamble/SFD, then one or more bytes MSB-first, then a tail. It replaces the free-running clk_bit encoder wherever a framed, flow-controlled link from clk_sys is needed.

Parameters:
HALF_BIT_CYCLES, 4, clk_sys cycles per Manchester half-bit; must be >= 2.
PREAMBLE_BITS, 8, preamble+SFD length in bits; must be even and >= 4.
INVERT_POLARITY, 1'b0, 0 = IEEE 802.3 convention, 1 = G.E. Thomas convention (line complemented while driving).

Ports:
clk_sys  input  1  system clock; all logic on its rising edge.
rst_n  input  1  synchronous active-low reset.
tx_data  input  8  byte to send, MSB first.
tx_valid  input  1  tx_data valid.
tx_ready  output  1  byte accepted on a cycle where tx_valid && tx_ready.
manchester_out  output  1  encoded line, registered.
tx_oe  output  1  line driver enable, registered; 1 from the first preamble half-bit to the last tail cycle.
tx_busy  output  1  frame in progress, registered.

Behaviour:
- Clock and reset: one clock, clk_sys; reset is synchronous and active-low, rst_n.
- Reset values: manchester_out=0, tx_oe=0, tx_busy=0, state=IDLE, counters=0.
- tx_ready is combinational and is forced to 0 while rst_n=0.
- Encoding, with ph=0 for the first half-bit and ph=1 for the second:
  - INVERT_POLARITY=0: line = bit ^ ~ph, so 1 is sent low-then-high and 0 is sent high-then-low.
  - INVERT_POLARITY=1: the line is complemented.
  - The idle level is always 0 when tx_oe=0, regardless of polarity.
- Timing:
  - A divider counts 0..HALF_BIT_CYCLES-1; half_tick is asserted on the terminal count.
  - ph toggles on half_tick.
  - A bit ends on half_tick with ph=1.
- States: IDLE -> PREAMBLE -> DATA -> TAIL -> IDLE.
- IDLE:
  - tx_ready=1.
  - On a transfer: latch tx_data, clear the divider, set bit index to 0, enter PREAMBLE.
  - tx_oe and tx_busy rise on the next edge.
  - The first preamble half-bit appears on the cycle after acceptance (latency 1).
- PREAMBLE:
  - Bit i = ~i[0] for i < PREAMBLE_BITS-1; the last bit = 1.
  - For the default this gives 1,0,1,0,1,0,1,1; the trailing "11" is the SFD.
- DATA:
  - Bits 7..0 of the shift register are sent.
  - tx_ready=1 only on the last clk_sys cycle of bit 0 (half_tick, ph=1).
  - Transfer on that cycle: load the new byte and continue DATA with no gap or preamble.
  - No transfer on that cycle: enter TAIL.
- TAIL:
  - Line driven 0 with tx_oe=1 for 2 bit times (4*HALF_BIT_CYCLES cycles).
  - Then IDLE, with tx_oe=0 and tx_busy=0 on the same edge.
- tx_valid outside a ready cycle is ignored. tx_data only needs to be stable on the transfer cycle.
- Reset mid-frame: on the next edge all state and outputs return to reset values and the partial frame is abandoned. After release, the next accepted byte starts a fresh preamble.
- Counters: the divider is $clog2(HALF_BIT_CYCLES) bits and the bit index is $clog2(max(PREAMBLE_BITS,9)) bits; both wrap only through explicit loads.

Optional Feature:
MANCH_TX_PARITY_EN:
- Defined: a 9th bit (even parity = ^byte) is sent after bit 0 of every byte, and the tx_ready load cycle moves to the end of the parity bit.
- Undefined: 8 bits per byte and no parity logic.

Decomposition:
- manchester_pkg holds:
  - tx_state_t enum (IDLE, PREAMBLE, DATA, TAIL).
  - LINE_IDLE_LEVEL.
  - TAIL_BITS=2.
  - Encode function manch_enc(bit, ph, inv).
- Sub-module manchester_bit_timer: divider plus phase flop, exporting half_tick, ph and bit_end, with a synchronous clear input.

Test Plan:
Defaults, with the accept cycle = 0.
- Single 0xA5:
  - manchester_out: cycles 1-4 = 0, cycles 5-8 = 1 (preamble bit 1).
  - Preamble occupies cycles 1-64, data 65-128, tail 129-144 (line 0, tx_oe=1).
  - Cycle 145: tx_busy=0, tx_oe=0, tx_ready=1.
- Back-to-back 0x00 then 0xFF with tx_valid held:
  - tx_ready pulses only at cycles 0 and 128.
  - 0xFF occupies 129-192 with no preamble; tail 193-208.
- tx_valid low in DATA: tx_ready stays 0 except on the bit-0 end cycle, and no extra byte is taken.
- rst_n=0 at cycle 70 for 1 cycle: cycle 71 has out=0, oe=0, busy=0. A new byte accepted after release restarts the preamble at half-bit 1.
- INVERT_POLARITY=1 with 0xA5: the waveform between cycles 1 and 144 is the bitwise complement of case 1; idle is still 0.
- MANCH_TX_PARITY_EN with 0x07: the parity bit (1) is at cycles 129-136 and the tail is at 137-152.
